// File: rtl/d_alu.sv
// d_alu: 8-bit combinational ALU with a registered {N,Z,C,V} flag register.
// Define DALU_SHIFT_EN to build the shifter for opcodes 9-11 (SHL/SHR/ASR).
`define OP_PASS  4'd0
`define OP_ADD   4'd1
`define OP_ADC   4'd2
`define OP_SUB   4'd3
`define OP_SBC   4'd4
`define OP_AND   4'd5
`define OP_OR    4'd6
`define OP_XOR   4'd7
`define OP_NOT   4'd8
`define OP_SHL   4'd9
`define OP_SHR   4'd10
`define OP_ASR   4'd11
`define OP_INC   4'd12
`define OP_DEC   4'd13
`define OP_CMP   4'd14
`define OP_PASSA 4'd15

module d_alu (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [3:0] op_i,
  input  logic       flag_we_i,
  output logic [7:0] out_o,
  output logic [3:0] flags_o
);

  logic [3:0] flags_q, flags_d;
  logic [8:0] res;
  logic       c_q, c_d, v_d;

  assign c_q = flags_q[1];

  always_comb begin
    res = 9'd0;
    c_d = 1'b0;
    v_d = 1'b0;
    case (op_i)
      `OP_ADD: begin
        res = {1'b0, a_i} + {1'b0, b_i};
        c_d = res[8];
        v_d = ~(a_i[7] ^ b_i[7]) & (res[7] ^ a_i[7]);
      end
      `OP_ADC: begin
        res = {1'b0, a_i} + {1'b0, b_i} + {8'd0, c_q};
        c_d = res[8];
        v_d = ~(a_i[7] ^ b_i[7]) & (res[7] ^ a_i[7]);
      end
      // Subtractions: bit 8 set means borrow, so C is its inverse.
      `OP_SUB, `OP_CMP: begin
        res = {1'b0, a_i} - {1'b0, b_i};
        c_d = ~res[8];
        v_d = (a_i[7] ^ b_i[7]) & (res[7] ^ a_i[7]);
      end
      `OP_SBC: begin
        res = {1'b0, a_i} - {1'b0, b_i} - {8'd0, ~c_q};
        c_d = ~res[8];
        v_d = (a_i[7] ^ b_i[7]) & (res[7] ^ a_i[7]);
      end
      `OP_AND: res = {1'b0, a_i & b_i};
      `OP_OR:  res = {1'b0, a_i | b_i};
      `OP_XOR: res = {1'b0, a_i ^ b_i};
      `OP_NOT: res = {1'b0, ~b_i};
`ifdef DALU_SHIFT_EN
      `OP_SHL: begin
        res = {1'b0, a_i[6:0], 1'b0};
        c_d = a_i[7];
      end
      `OP_SHR: begin
        res = {2'b00, a_i[7:1]};
        c_d = a_i[0];
      end
      `OP_ASR: begin
        res = {1'b0, a_i[7], a_i[7:1]};
        c_d = a_i[0];
      end
`endif
      `OP_INC: begin
        res = {1'b0, a_i} + 9'd1;
        c_d = res[8];
        v_d = ~a_i[7] & res[7];
      end
      `OP_DEC: begin
        res = {1'b0, a_i} - 9'd1;
        c_d = ~res[8];
        v_d = a_i[7] & ~res[7];
      end
      `OP_PASSA: res = {1'b0, a_i};
      // PASS, and opcodes 9-11 when the shifter is not built.
      default: res = {1'b0, b_i};
    endcase
  end

  assign flags_d = {res[7], (res[7:0] == 8'd0), c_d, v_d};
  assign out_o   = (op_i == `OP_CMP) ? a_i : res[7:0];
  assign flags_o = flags_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= 4'b0000;
    end else if (flag_we_i) begin
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_d_alu.sv
// tb_d_alu: directed and randomized checks of d_alu against an integer-arithmetic model.
module tb_d_alu;

  localparam int OpPass = 0, OpAdd = 1, OpAdc = 2, OpSub = 3, OpSbc = 4, OpAnd = 5, OpOr = 6;
  localparam int OpXor = 7, OpNot = 8, OpShl = 9, OpShr = 10, OpAsr = 11, OpInc = 12;
  localparam int OpDec = 13, OpCmp = 14, OpPassa = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'd0, b = 8'd0;
  logic [3:0] op = 4'd0;
  logic       we = 1'b0;
  logic [7:0] out;
  logic [3:0] flags;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  d_alu dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .a_i      (a),
    .b_i      (b),
    .op_i     (op),
    .flag_we_i(we),
    .out_o    (out),
    .flags_o  (flags)
  );

  always #5 clk = ~clk;

  // Returns {out[7:0], N, Z, C, V} computed with plain signed/unsigned integers.
  function automatic logic [11:0] model(input int ua, input int ub, input int opc, input int c);
    int sa, sb, r, o, cf, vf, bw, sr;
    bit shift_en;
`ifdef DALU_SHIFT_EN
    shift_en = 1'b1;
`else
    shift_en = 1'b0;
`endif
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    cf = 0; vf = 0; sr = 0; bw = 1 - c;
    case (opc)
      OpAdd:   begin r = ua + ub;      cf = int'(r > 255); sr = sa + sb; end
      OpAdc:   begin r = ua + ub + c;  cf = int'(r > 255); sr = sa + sb + c; end
      OpSub, OpCmp: begin r = ua - ub; cf = int'(ua >= ub); sr = sa - sb; end
      OpSbc:   begin r = ua - ub - bw; cf = int'(ua >= ub + bw); sr = sa - sb - bw; end
      OpAnd:   r = ua & ub;
      OpOr:    r = ua | ub;
      OpXor:   r = ua ^ ub;
      OpNot:   r = 255 - ub;
      OpShl:   if (shift_en) begin r = ua * 2; cf = ua / 128; end else r = ub;
      OpShr:   if (shift_en) begin r = ua / 2; cf = ua % 2; end else r = ub;
      OpAsr:   if (shift_en) begin r = ua / 2 + ((ua >= 128) ? 128 : 0); cf = ua % 2; end
               else r = ub;
      OpInc:   begin r = ua + 1; cf = int'(r > 255); sr = sa + 1; end
      OpDec:   begin r = ua - 1; cf = int'(ua >= 1); sr = sa - 1; end
      OpPassa: r = ua;
      default: r = ub;
    endcase
    if (opc inside {OpAdd, OpAdc, OpSub, OpCmp, OpSbc, OpInc, OpDec})
      vf = int'(sr > 127 || sr < -128);
    r = r & 255;
    o = (opc == OpCmp) ? ua : r;
    model = {o[7:0], r >= 128, r == 0, cf[0], vf[0]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference flag register, fed by the model's next-flag value.
  logic [3:0]  m_flags;
  logic [11:0] m_next;
  assign m_next = model(int'(a), int'(b), int'(op), int'(m_flags[1]));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_flags <= 4'b0000;
    else if (we) m_flags <= m_next[3:0];
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_out", int'(out), int'(m_next[11:4]));
      check("cyc_flags", int'(flags), int'(m_flags));
    end
  end

  task automatic drive(input int ua, input int ub, input int opc, input logic w);
    a = ua[7:0]; b = ub[7:0]; op = opc[3:0]; we = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Pin the model with hand-computed values.
    check("model_add_carry", int'(model(200, 100, OpAdd, 0)), 12'h2C2);
    check("model_cmp", int'(model(3, 5, OpCmp, 0)), 12'h038);
    check("model_sub_ovf", int'(model(8'h80, 1, OpSub, 0)), 12'h7F3);
    check("model_sbc_nc", int'(model(5, 5, OpSbc, 0)), 12'hFF8);

    drive(200, 100, OpAdd, 1'b1);
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_flags", int'(flags), 4'b0000);
    check("rst_out", int'(out), 44);
    rst_n = 1'b1;
    tick();
    check("post_rst_out", int'(out), 44);
    check("post_rst_flags", int'(flags), 4'b0010);

    drive(0, 1, OpPass, 1'b1); #1;
    check("pass_out", int'(out), 1);
    tick();
    drive(1, 200, OpAdd, 1'b1); #1;
    check("add_out", int'(out), 201);
    tick();
    check("add_flags", int'(flags), 4'b1000);

    drive(8'hFF, 1, OpAdd, 1'b1); #1;
    check("carry_out", int'(out), 0);
    tick();
    check("carry_flags", int'(flags), 4'b0110);
    drive(0, 0, OpAdc, 1'b0); #1;
    check("adc_out", int'(out), 1);
    repeat (2) tick();
    check("adc_hold_flags", int'(flags), 4'b0110);
    check("adc_hold_out", int'(out), 1);

    drive(5, 5, OpSub, 1'b1); #1;
    check("sub_out", int'(out), 0);
    tick();
    check("sub_flags", int'(flags), 4'b0110);
    drive(3, 5, OpCmp, 1'b1); #1;
    check("cmp_out", int'(out), 3);
    tick();
    check("cmp_flags", int'(flags), 4'b1000);

    drive(8'h7F, 1, OpAdd, 1'b1); #1;
    check("addv_out", int'(out), 8'h80);
    tick();
    check("addv_flags", int'(flags), 4'b1001);
    drive(8'h80, 1, OpSub, 1'b1); #1;
    check("subv_out", int'(out), 8'h7F);
    tick();
    check("subv_flags", int'(flags), 4'b0011);

    drive(8'h81, 8'h55, OpShl, 1'b1); #1;
`ifdef DALU_SHIFT_EN
    check("shl_out", int'(out), 8'h02);
    tick();
    check("shl_flags", int'(flags), 4'b0010);
`else
    check("shl_out", int'(out), 8'h55);
    tick();
    check("shl_flags", int'(flags), 4'b0000);
`endif

    // Asynchronous clear between edges.
    drive(8'hFF, 1, OpAdd, 1'b1);
    tick();
    #1 rst_n = 1'b0;
    #1 check("async_rst_flags", int'(flags), 4'b0000);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 15)), logic'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 63) == 0) begin
        #2 rst_n = 1'b0;
      end
      tick();
      rst_n = 1'b1;
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
